// File: rtl/aes256_kex.sv
// Iterative AES-256 key expansion: one 128-bit round key per cycle, SubWord through an external
// S-box port. Optional zeroize support is enabled with `define AES256_KEX_ZEROIZE_EN.
module aes256_kex (
    input  logic               i_clk,
    input  logic               i_rst_n,
`ifdef AES256_KEX_ZEROIZE_EN
    input  logic               i_zero,
`endif
    input  logic [255:0]       i_key,
    input  logic               i_key_en,
    output logic [128*15-1:0]  o_keyex,
    output logic               o_key_ok,
    output logic               o_busy,
    output logic [31:0]        o_sbox_din,
    input  logic [31:0]        i_sbox_dout
);

    logic [127:0] rk_q [15];
    logic [3:0]   count_q;
    logic         busy_q;
    logic         key_ok_q;

    logic [3:0]   prev_idx;
    logic [3:0]   prev2_idx;
    logic [3:0]   wr_idx;
    logic [31:0]  t;
    logic [127:0] prev2;
    logic [7:0]   rcon;
    logic [31:0]  temp;
    logic [31:0]  w0, w1, w2, w3;

    // Idle (count 0) points the S-box at RK[1] rotated so the lookup value stays static.
    always_comb begin
        prev_idx  = (count_q == 4'd0) ? 4'd1 : count_q;
        prev2_idx = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
        wr_idx    = count_q + 4'd1;
        t         = rk_q[prev_idx][31:0];
        prev2     = rk_q[prev2_idx];

        // Even round-key index k = count + 1 uses RotWord and RCON.
        if (count_q[0] || (count_q == 4'd0)) begin
            o_sbox_din = {t[23:0], t[31:24]};
        end else begin
            o_sbox_din = t;
        end

        rcon = 8'h00;
        case (count_q)
            4'd1:    rcon = 8'h01;
            4'd3:    rcon = 8'h02;
            4'd5:    rcon = 8'h04;
            4'd7:    rcon = 8'h08;
            4'd9:    rcon = 8'h10;
            4'd11:   rcon = 8'h20;
            4'd13:   rcon = 8'h40;
            default: rcon = 8'h00;
        endcase

        temp = i_sbox_dout ^ {rcon, 24'h0};
        w0   = prev2[127:96] ^ temp;
        w1   = prev2[95:64]  ^ w0;
        w2   = prev2[63:32]  ^ w1;
        w3   = prev2[31:0]   ^ w2;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rk_q[i] <= '0;
            end
            count_q  <= 4'd0;
            busy_q   <= 1'b0;
            key_ok_q <= 1'b0;
        end else begin
`ifdef AES256_KEX_ZEROIZE_EN
            if (i_zero) begin
                for (int i = 0; i < 15; i++) begin
                    rk_q[i] <= '0;
                end
                count_q  <= 4'd0;
                busy_q   <= 1'b0;
                key_ok_q <= 1'b0;
            end else
`endif
            if (i_key_en) begin
                rk_q[0] <= i_key[255:128];
                rk_q[1] <= i_key[127:0];
`ifdef AES256_KEX_ZEROIZE_EN
                for (int i = 2; i < 15; i++) begin
                    rk_q[i] <= '0;
                end
`endif
                count_q  <= 4'd1;
                busy_q   <= 1'b1;
                key_ok_q <= 1'b0;
            end else if (busy_q) begin
                rk_q[wr_idx] <= {w0, w1, w2, w3};
                if (count_q == 4'd13) begin
                    count_q  <= 4'd0;
                    busy_q   <= 1'b0;
                    key_ok_q <= 1'b1;
                end else begin
                    count_q <= count_q + 4'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 15; g++) begin : g_pack
        assign o_keyex[128*(15-g)-1 -: 128] = rk_q[g];
    end

    assign o_busy   = busy_q;
    assign o_key_ok = key_ok_q;

endmodule

// File: tb/tb_aes256_kex.sv
// Directed bench for aes256_kex: FIPS-197 key schedules, restart, completion-edge load, async reset.
module tb_aes256_kex;

    logic               clk;
    logic               rst_n;
    logic [255:0]       key;
    logic               key_en;
    logic [128*15-1:0]  keyex;
    logic               key_ok;
    logic               busy;
    logic [31:0]        sbox_din;
    logic [31:0]        sbox_dout;
`ifdef AES256_KEX_ZEROIZE_EN
    logic               zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] KeyC3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KeyA3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes256_kex dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
`ifdef AES256_KEX_ZEROIZE_EN
        .i_zero      (zero),
`endif
        .i_key       (key),
        .i_key_en    (key_en),
        .o_keyex     (keyex),
        .o_key_ok    (key_ok),
        .o_busy      (busy),
        .o_sbox_din  (sbox_din),
        .i_sbox_dout (sbox_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:2047] sbox_tab;
    initial begin
        sbox_tab = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    end

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tab[8*x +: 8];
    endfunction

    always_comb begin
        sbox_dout = {sb(sbox_din[31:24]), sb(sbox_din[23:16]),
                     sb(sbox_din[15:8]), sb(sbox_din[7:0])};
    end

    function automatic logic [127:0] get_rk(input int k);
        return keyex[128*(15-k)-1 -: 128];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [255:0] k);
        @(negedge clk);
        key    = k;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
    endtask

    // Called at the first negedge after the load edge; lat counts edges after it.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!key_ok && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        string        name;
        int           key_id;
        int           k;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   lat, bcnt;
    bit   ok_seen;
    logic [128*15-1:0] snap;

    task automatic check_table(input int key_id);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].key_id == key_id) check(vecs[i].name, get_rk(vecs[i].k), vecs[i].exp);
        end
    endtask

    initial begin
        vecs[0] = '{"c3_rk0",  0, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{"c3_rk1",  0, 1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2] = '{"c3_rk2",  0, 2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3] = '{"c3_rk3",  0, 3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[4] = '{"c3_rk14", 0, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[5] = '{"a3_rk0",  1, 0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[6] = '{"a3_rk14", 1, 14, 128'hfe4890d1e6188d0b046df344706c631e};

        rst_n  = 1'b0;
        key    = '0;
        key_en = 1'b0;
`ifdef AES256_KEX_ZEROIZE_EN
        zero   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_keyex_rk0", get_rk(0), '0);
        check("rst_keyex_rk14", get_rk(14), '0);
        check("rst_key_ok", 128'(key_ok), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;

        // FIPS-197 C.3
        load(KeyC3);
        check("c3_busy_after_load", 128'(busy), 128'd1);
        wait_done(lat, bcnt);
        check("c3_latency", 128'(lat), 128'd13);
        check("c3_busy_cycles", 128'(bcnt), 128'd13);
        check_table(0);
        check("idle_sbox_din", 128'(sbox_din), 128'h1d1e1f1c);
        snap = keyex;
        repeat (3) @(negedge clk);
        check("idle_stable_rk14", get_rk(14), snap[127:0]);
        check("idle_key_ok_holds", 128'(key_ok), 128'd1);

        // FIPS-197 A.3
        load(KeyA3);
        check("a3_ok_dropped", 128'(key_ok), 128'd0);
        wait_done(lat, bcnt);
        check("a3_latency", 128'(lat), 128'd13);
        check("a3_busy_cycles", 128'(bcnt), 128'd13);
        check_table(1);

        // Restart mid-expansion with the C.3 key
        load(KeyA3);
        ok_seen = 1'b0;
        repeat (4) begin
            ok_seen |= key_ok;
            @(negedge clk);
        end
        load(KeyC3);
        wait_done(lat, bcnt);
        check("restart_latency", 128'(lat), 128'd13);
        check("restart_busy_cycles", 128'(bcnt), 128'd13);
        check("restart_no_early_ok", 128'(ok_seen), 128'd0);
        check_table(0);

        // Load on the completion edge wins
        load(KeyC3);
        repeat (12) @(negedge clk);
        check("pre_completion_busy", 128'(busy), 128'd1);
        key    = KeyA3;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
        check("collide_ok_low", 128'(key_ok), 128'd0);
        check("collide_busy", 128'(busy), 128'd1);
        wait_done(lat, bcnt);
        check("collide_latency", 128'(lat), 128'd13);
        check_table(1);

        // Asynchronous reset mid-expansion, away from any clock edge
        load(KeyC3);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rk0", get_rk(0), '0);
        check("async_rst_rk5", get_rk(5), '0);
        check("async_rst_busy", 128'(busy), 128'd0);
        check("async_rst_key_ok", 128'(key_ok), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_key_ok", 128'(key_ok), 128'd0);

`ifdef AES256_KEX_ZEROIZE_EN
        load(KeyC3);
        wait_done(lat, bcnt);
        check_table(0);
        @(negedge clk);
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        check("zero_rk0", get_rk(0), '0);
        check("zero_rk14", get_rk(14), '0);
        check("zero_key_ok", 128'(key_ok), 128'd0);
        key    = KeyA3;
        key_en = 1'b1;
        zero   = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
        zero   = 1'b0;
        check("zero_beats_load_busy", 128'(busy), 128'd0);
        check("zero_beats_load_rk0", get_rk(0), '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
